fir_decim_out: RTL and testbench
================================

Name: fir_decim_out

Overview:
- Output stage directly downstream of the 37-tap symmetric FIR.
- Takes the FIR's 20-bit signed MAC result each sample and decimates it by DECIM.
- Rounds and saturates each kept sample back to 14 bits.
- Buffers kept samples in a small FIFO and hands them to the consumer over a valid/ready handshake, with saturation and overflow reporting.

Parameters:
- MAC_WL, 20, input sample width (FIR output width), signed.
- OUT_WL, 14, output sample width, signed.
- SHIFT, 6, LSBs removed by rounding; must be ≥1.
- DECIM, 2, decimation factor; ≥1. A value of 1 means pass-through.
- PHASE, 0, index of the kept sample within each DECIM group; 0 ≤ PHASE < DECIM.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is a new FIR sample this cycle. Tie to 1 for a free-running FIR.
- in_data  in  MAC_WL  signed FIR output sample.
- out_valid  out  1  out_data holds a buffered sample.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  OUT_WL  signed decimated, rounded, saturated sample.
- sat_pulse  out  1  registered one-cycle pulse: the kept sample written to stage 1 this cycle was saturated.
- ovf_sticky  out  1  set when a kept sample is dropped because the FIFO is full. Cleared only by rst.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - phase counter = 0; stage-1 valid = 0; FIFO emptied (pointers and count = 0).
  - out_valid = 0, out_data = 0, sat_pulse = 0, ovf_sticky = 0.
  - Reset wins over every simultaneous event, including mid-burst and with the FIFO full.
- Decimation:
  - phase counter increments modulo DECIM on each in_valid=1 cycle and holds otherwise.
  - A sample is kept iff in_valid=1 and phase==PHASE before the increment.
- Rounding (round half up, toward +inf):
  - r = (sign-extended in_data to MAC_WL+1 bits + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift.
- Saturation:
  - r > 2^(OUT_WL-1)-1 gives 8191; r < -2^(OUT_WL-1) gives -8192 (defaults).
  - Saturation sets sat_pulse for exactly the cycle that the stage-1 register holds the sample.
- Stage 1:
  - Registers the kept flag and the rounded/saturated value on the edge the sample is presented.
  - The stage-1 result is pushed into the FIFO on the next edge.
- Latency: sample presented before edge N is visible on out_data/out_valid after edge N+1 if the FIFO was empty (2 cycles).
- FIFO:
  - Synchronous FIFO; out_data is driven from the head entry; out_valid = (count≠0).
  - Pop when out_valid && out_ready.
  - out_data holds stable while out_valid=1 and out_ready=0. out_data is 0 when empty.
- Push/pop rules:
  - Push when stage-1 is valid and (count<FIFO_DEPTH, or a pop occurs the same cycle).
  - Simultaneous push and pop at full: both happen; count unchanged; no overflow.
  - Simultaneous push and pop when empty: impossible (out_valid=0); push only.
- Overflow:
  - Stage-1 valid, FIFO full, and no pop: the sample is dropped and ovf_sticky is set.
  - FIFO contents are untouched; ovf_sticky stays 1 until rst.
- Pointers wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits.
- No backpressure toward the FIR: the upstream is free-running. Overflow is the only loss mechanism and is always flagged.

Decomposition:
- fir_pkg holds:
  - shared widths WL=14 and MAC_WL=20;
  - a function sat_round(x) implementing the round/saturate rule;
  - the localparams derived from FIFO_DEPTH (pointer and count widths).
- One sub-module, fir_out_fifo: synchronous FIFO with push, pop, data, count, full and empty.
- Decimation counter, rounding and stage 1 stay in fir_decim_out.

Test Plan:
- Ramp, DECIM=2, PHASE=0, in_valid=1, out_ready=1: in_data = 0,64,128,192,… → out_data = 0,2,4,… (every other sample /64); first out_valid two edges after the first sample.
- Rounding:
  - in_data = 31 → 0; 32 → 1; -32 → 0; -33 → -1.
  - in_data = 524287 → 8191 with sat_pulse=1.
  - in_data = -524288 → -8192 with sat_pulse=0 (no overflow on the negative side).
- Backpressure: out_ready=0 for 20 cycles with a continuous input → FIFO fills to 4 entries. The 5th kept sample sets ovf_sticky=1. After out_ready=1 the first 4 kept samples drain in order; ovf_sticky stays 1.
- Full with simultaneous push and pop: FIFO full, out_ready=1 on the cycle a kept sample arrives → count stays 4, no overflow, order preserved.
- in_valid gaps: in_valid toggling 1,0,1,0 → the phase counter advances only on valid cycles, and the kept samples match the dense-input result.
- Reset mid-operation: rst=1 for one edge with the FIFO holding 3 entries and stage-1 valid → next cycle out_valid=0, out_data=0, ovf_sticky=0, phase=0. The first kept sample after reset is the first in_valid sample.

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR output stage.
//   WL, MAC_WL       : output sample width and FIR accumulator width (signed)
//   SHIFT            : LSBs dropped by rounding
//   FIFO_DEPTH       : default depth of the output FIFO, with the pointer and
//                      count widths derived from it
//   rounded_t        : rounded sample plus a flag saying it was clipped
//   sat_round()      : round half up, then saturate to WL bits
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int WL         = 14;
  localparam int MAC_WL     = 20;
  localparam int SHIFT      = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  // Limits and rounding constant expressed at the widened MAC_WL+1 width so
  // every comparison in sat_round is signed and width-matched.
  localparam logic signed [MAC_WL:0] SAT_HI     = (MAC_WL+1)'((2**(WL-1)) - 1);
  localparam logic signed [MAC_WL:0] SAT_LO     = (MAC_WL+1)'(-(2**(WL-1)));
  localparam logic signed [MAC_WL:0] ROUND_HALF = (MAC_WL+1)'(2**(SHIFT-1));

  typedef struct packed {
    logic                 sat;
    logic signed [WL-1:0] value;
  } rounded_t;

  // The extra MSB keeps the +half addition from wrapping at the positive
  // full-scale input; the arithmetic shift then floors, giving round half up.
  function automatic rounded_t sat_round(input logic signed [MAC_WL-1:0] x);
    logic signed [MAC_WL:0] sum;
    logic signed [MAC_WL:0] r;
    rounded_t               res;
    sum = {x[MAC_WL-1], x} + ROUND_HALF;
    r   = sum >>> SHIFT;
    if (r > SAT_HI) begin
      res.sat   = 1'b1;
      res.value = SAT_HI[WL-1:0];
    end else if (r < SAT_LO) begin
      res.sat   = 1'b1;
      res.value = SAT_LO[WL-1:0];
    end else begin
      res.sat   = 1'b0;
      res.value = r[WL-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// ---------------------------------------------------------------------------
// fir_out_fifo
// Synchronous FIFO holding decimated output samples.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata (accepted when not full, or when a pop also occurs)
//   pop      : remove the head entry (ignored when empty)
//   wdata    : sample to write
//   rdata    : head entry (raw storage, meaningful only when not empty)
//   count    : number of stored entries, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// ---------------------------------------------------------------------------
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = WL,
  parameter int P_W   = $clog2(DEPTH),
  parameter int C_W   = P_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [C_W-1:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [P_W-1:0]   wr_ptr;
  logic [P_W-1:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == C_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO can
  // still take a write.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + C_W'(do_push) - C_W'(do_pop);
    end
  end

  // Storage carries no reset; stale entries are never visible because the
  // read side is qualified by empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fir_decim_out.sv
// ---------------------------------------------------------------------------
// fir_decim_out
// Output stage after the symmetric FIR: decimate, round, saturate, buffer.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : in_data carries a new FIR sample this cycle
//   in_data    : signed MAC_WL-bit FIR result
//   out_valid  : out_data holds a buffered sample
//   out_ready  : consumer takes out_data this cycle
//   out_data   : signed WL-bit decimated sample (0 when nothing buffered)
//   sat_pulse  : high while stage 1 holds a kept sample that was clipped
//   ovf_sticky : a kept sample was dropped on a full FIFO; cleared by rst
// ---------------------------------------------------------------------------
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int DECIM      = 2,
  parameter int PHASE      = 0,
  parameter int FIFO_DEPTH = fir_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [MAC_WL-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WL-1:0]     out_data,
  output logic                     sat_pulse,
  output logic                     ovf_sticky
);

  // A one-bit counter is kept even for DECIM=1 so the logic stays uniform;
  // it then never leaves 0 and every valid sample is kept.
  localparam int                PH_W       = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(DECIM - 1);
  localparam logic [PH_W-1:0]   KEEP_PHASE = PH_W'(PHASE);
  localparam int                F_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                F_CNT_W    = F_PTR_W + 1;

  logic [PH_W-1:0]    phase;
  logic               keep;
  rounded_t           rounded;
  logic               s1_valid;
  logic [WL-1:0]      s1_data;
  logic               push;
  logic               pop;
  logic [WL-1:0]      fifo_rdata;
  logic [F_CNT_W-1:0] fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  assign keep    = in_valid && (phase == KEEP_PHASE);
  assign rounded = sat_round(in_data);

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_empty ? '0 : $signed(fifo_rdata);
  assign pop       = out_valid && out_ready;
  assign push      = s1_valid && (!fifo_full || pop);

  // Phase counter, stage-1 register and overflow flag. The FIR cannot be
  // stalled, so a stage-1 sample that finds the FIFO full with no pop is
  // lost and the loss is latched until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      sat_pulse  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (in_valid) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      s1_valid  <= keep;
      s1_data   <= rounded.value;
      sat_pulse <= keep && rounded.sat;
      if (s1_valid && fifo_full && !pop) ovf_sticky <= 1'b1;
    end
  end

  fir_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WL),
    .P_W   (F_PTR_W),
    .C_W   (F_CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (s1_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fir_decim_out.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_out
// Self-checking bench for fir_decim_out. A queue-based reference model tracks
// which samples are kept, their rounded/saturated values and the FIFO
// contents; a compare process checks every output on every falling edge.
// Directed sections check hand-computed values for ramp, rounding,
// saturation, backpressure, full push+pop, gaps and mid-run reset, followed
// by a randomized run.
// ---------------------------------------------------------------------------
module tb_fir_decim_out;

  localparam int DECIM = 2;
  localparam int PHASE = 0;
  localparam int DEPTH = 4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [19:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [13:0] out_data;
  logic               sat_pulse;
  logic               ovf_sticky;

  int nCompared;
  int nMismatched;

  int  refQ[$];
  bit  refS1Valid;
  int  refS1Val;
  bit  refSatP;
  bit  refOvf;
  int  validIdx;
  bit  modelLive;

  int popped[$];
  int expQ[$];
  int keptIn[$];

  fir_decim_out #(
    .DECIM      (DECIM),
    .PHASE      (PHASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sat_pulse  (sat_pulse),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round half up as floor((x + 32) / 64), then clip to 14-bit signed.
  task automatic roundSat(input int x, output int v, output bit s);
    int t;
    int q;
    t = x + 32;
    q = t / 64;
    if (t < 0 && (t % 64) != 0) q = q - 1;
    s = 1'b0;
    if (q > 8191) begin
      q = 8191;
      s = 1'b1;
    end else if (q < -8192) begin
      q = -8192;
      s = 1'b1;
    end
    v = q;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit r);
    in_valid  = v;
    in_data   = 20'(d);
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, int'($urandom_range(0, 4095)), r);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkPopped(input string name);
    checkOutput({name, "_count"}, popped.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < popped.size(); i++)
      checkOutput($sformatf("%s_%0d", name, i), popped[i], expQ[i]);
  endtask

  function automatic int randSample();
    return int'($urandom_range(0, 1048575)) - 524288;
  endfunction

  // Reference model: one stage of delay, then an ideal bounded queue.
  // Samples are kept by their index among valid inputs.
  initial begin
    modelLive = 1'b0;
    forever begin
      int  v;
      bit  s;
      bit  keepNow;
      @(posedge clk);
      if (rst) begin
        refQ.delete();
        refS1Valid = 1'b0;
        refSatP    = 1'b0;
        refOvf     = 1'b0;
        validIdx   = 0;
        modelLive  = 1'b1;
      end else begin
        if (refQ.size() != 0 && out_ready) void'(refQ.pop_front());
        if (refS1Valid) begin
          if (refQ.size() < DEPTH) refQ.push_back(refS1Val);
          else refOvf = 1'b1;
        end
        roundSat(int'(in_data), v, s);
        keepNow    = in_valid && ((validIdx % DECIM) == PHASE);
        refS1Valid = keepNow;
        refS1Val   = v;
        refSatP    = keepNow && s;
        if (in_valid) validIdx++;
      end
    end
  end

  // Every-cycle comparison against the model, plus a log of accepted outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (modelLive) begin
        checkOutput("out_valid", int'(out_valid), int'(refQ.size() != 0));
        checkOutput("out_data", int'(out_data), (refQ.size() != 0) ? refQ[0] : 0);
        checkOutput("sat_pulse", int'(sat_pulse), int'(refSatP));
        checkOutput("ovf_sticky", int'(ovf_sticky), int'(refOvf));
        if (out_valid && out_ready) popped.push_back(int'(out_data));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v;
    bit s;
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;

    // Model sanity against hand-computed roundings.
    roundSat(-33, v, s);
    checkOutput("model_round_m33", v, -1);
    roundSat(524287, v, s);
    checkOutput("model_sat_pos", v, 8191);
    checkOutput("model_sat_pos_flag", int'(s), 1);

    doReset();
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_sat", int'(sat_pulse), 0);
    checkOutput("reset_ovf", int'(ovf_sticky), 0);

    $display("[TB] ramp");
    popped.delete();
    applyStimulus(1'b1, 0, 1'b1);
    checkOutput("ramp_latency_edge1", int'(out_valid), 0);
    applyStimulus(1'b1, 64, 1'b1);
    checkOutput("ramp_latency_edge2", int'(out_valid), 1);
    checkOutput("ramp_first_data", int'(out_data), 0);
    for (int i = 2; i < 8; i++) applyStimulus(1'b1, 64 * i, 1'b1);
    idle(3, 1'b1);
    expQ = '{0, 2, 4, 6};
    checkPopped("ramp");

    $display("[TB] rounding");
    popped.delete();
    applyStimulus(1'b1, 31, 1'b0);
    applyStimulus(1'b1, randSample(), 1'b0);
    applyStimulus(1'b1, 32, 1'b0);
    applyStimulus(1'b1, randSample(), 1'b0);
    applyStimulus(1'b1, -32, 1'b0);
    applyStimulus(1'b1, randSample(), 1'b0);
    applyStimulus(1'b1, -33, 1'b0);
    applyStimulus(1'b1, randSample(), 1'b0);
    checkOutput("round_full_valid", int'(out_valid), 1);
    checkOutput("round_no_ovf", int'(ovf_sticky), 0);
    idle(5, 1'b1);
    expQ = '{0, 1, 0, -1};
    checkPopped("round");

    $display("[TB] saturation");
    popped.delete();
    applyStimulus(1'b1, 524287, 1'b1);
    checkOutput("sat_pos_pulse", int'(sat_pulse), 1);
    applyStimulus(1'b1, randSample(), 1'b1);
    checkOutput("sat_pulse_one_cycle", int'(sat_pulse), 0);
    applyStimulus(1'b1, -524288, 1'b1);
    checkOutput("sat_neg_no_pulse", int'(sat_pulse), 0);
    applyStimulus(1'b1, randSample(), 1'b1);
    idle(3, 1'b1);
    expQ = '{8191, -8192};
    checkPopped("sat");

    $display("[TB] backpressure");
    popped.delete();
    keptIn.delete();
    for (int i = 0; i < 20; i++) begin
      int d;
      d = randSample();
      if ((i % 2) == 0) keptIn.push_back(d);
      applyStimulus(1'b1, d, 1'b0);
    end
    checkOutput("bp_ovf_set", int'(ovf_sticky), 1);
    checkOutput("bp_valid", int'(out_valid), 1);
    idle(8, 1'b1);
    expQ.delete();
    for (int i = 0; i < 4; i++) begin
      roundSat(keptIn[i], v, s);
      expQ.push_back(v);
    end
    checkPopped("bp_drain");
    checkOutput("bp_ovf_stays", int'(ovf_sticky), 1);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, randSample(), 1'b0);
    checkOutput("mid_pre_valid", int'(out_valid), 1);
    rst = 1'b1;
    applyStimulus(1'b1, randSample(), 1'b1);
    rst = 1'b0;
    checkOutput("mid_out_valid", int'(out_valid), 0);
    checkOutput("mid_out_data", int'(out_data), 0);
    checkOutput("mid_ovf", int'(ovf_sticky), 0);
    checkOutput("mid_sat", int'(sat_pulse), 0);
    popped.delete();
    applyStimulus(1'b1, 576, 1'b1);
    applyStimulus(1'b1, randSample(), 1'b1);
    idle(4, 1'b1);
    expQ = '{9};
    checkPopped("mid_after");

    $display("[TB] full with push and pop");
    popped.delete();
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, ((i % 2) == 0) ? 640 * (i / 2 + 1) : randSample(), 1'b0);
    applyStimulus(1'b1, 3200, 1'b0);
    applyStimulus(1'b1, randSample(), 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("fullpp_no_ovf", int'(ovf_sticky), 0);
    checkOutput("fullpp_head", int'(out_data), 20);
    idle(6, 1'b1);
    expQ = '{10, 20, 30, 40, 50};
    checkPopped("fullpp");

    $display("[TB] in_valid gaps");
    popped.delete();
    applyStimulus(1'b1, 192, 1'b1);
    applyStimulus(1'b0, randSample(), 1'b1);
    applyStimulus(1'b1, randSample(), 1'b1);
    applyStimulus(1'b0, randSample(), 1'b1);
    applyStimulus(1'b1, 448, 1'b1);
    applyStimulus(1'b0, randSample(), 1'b1);
    applyStimulus(1'b1, randSample(), 1'b1);
    applyStimulus(1'b0, randSample(), 1'b1);
    applyStimulus(1'b1, 704, 1'b1);
    applyStimulus(1'b0, randSample(), 1'b1);
    applyStimulus(1'b1, randSample(), 1'b1);
    applyStimulus(1'b0, randSample(), 1'b1);
    idle(3, 1'b1);
    expQ = '{3, 7, 11};
    checkPopped("gaps");

    $display("[TB] randomized");
    for (int i = 0; i < 400; i++) begin
      int d;
      if (($urandom % 4) == 0) d = (($urandom % 2) == 0) ? 524287 - int'($urandom_range(0, 40))
                                                         : -524288 + int'($urandom_range(0, 40));
      else d = randSample();
      if (i == 200) rst = 1'b1;
      applyStimulus(($urandom % 4) != 0, d, ($urandom % 3) != 0);
      rst = 1'b0;
    end
    idle(8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
